// File: rtl/led_encoder_if.sv
// Packet/LED signal bundle between the packet source, led_encoder and the pad driver.
`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif

interface led_encoder_if #(
  parameter int W = `PACKET_SIZE
);
  logic [W-1:0] data;
  logic         led;
  logic         done;

  modport master (output data, input led, input done);
  modport slave  (input data, output led, output done);
endinterface

// File: rtl/led_encoder.sv
// Serial optical-link framer: IDLE latch, START violation, Manchester data MSB first, STOP gap.
// Optional even-parity bit after the LSB when ENCODER_PARITY_EN is defined.
`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif

module led_encoder #(
  parameter int PACKET_SIZE = `PACKET_SIZE,
  parameter int HALF_CYCLES = 1
) (
  input  logic          clock,
  input  logic          reset,
  led_encoder_if.slave  bus
);

`ifdef ENCODER_PARITY_EN
  localparam int NBITS = PACKET_SIZE + 1;
`else
  localparam int NBITS = PACKET_SIZE;
`endif
  localparam int HW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam int BW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic [HW-1:0]    r_hcnt, w_hcnt_nxt;
  logic             r_phase, w_phase_nxt;
  logic [BW-1:0]    r_bcnt, w_bcnt_nxt;
  logic [NBITS-1:0] r_shreg, w_shreg_nxt;
  logic             r_led, w_led_nxt;
  logic             r_done, w_done_nxt;
  logic             w_half_end;
  logic [NBITS-1:0] w_latch;

`ifdef ENCODER_PARITY_EN
  assign w_latch = {bus.data, ^bus.data};
`else
  assign w_latch = bus.data;
`endif

  assign w_half_end = (r_hcnt == HW'(HALF_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_phase_nxt = r_phase;
    w_bcnt_nxt  = r_bcnt;
    w_shreg_nxt = r_shreg;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_state_nxt = START;
        w_shreg_nxt = w_latch;
        w_hcnt_nxt  = '0;
        w_phase_nxt = 1'b0;
        w_bcnt_nxt  = '0;
      end
      START, STOP: begin
        if (w_half_end) begin
          w_hcnt_nxt = '0;
          if (r_phase) begin
            w_phase_nxt = 1'b0;
            w_state_nxt = (r_state == START) ? DATA : IDLE;
            w_done_nxt  = (r_state == STOP);
          end else begin
            w_phase_nxt = 1'b1;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + HW'(1);
        end
      end
      DATA: begin
        if (w_half_end) begin
          w_hcnt_nxt = '0;
          if (r_phase) begin
            // Second half done: advance to the next bit.
            w_phase_nxt = 1'b0;
            w_shreg_nxt = r_shreg << 1;
            if (r_bcnt == BW'(NBITS - 1)) begin
              w_bcnt_nxt  = '0;
              w_state_nxt = STOP;
            end else begin
              w_bcnt_nxt = r_bcnt + BW'(1);
            end
          end else begin
            w_phase_nxt = 1'b1;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + BW'(0) + HW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // LED is registered, so it is computed from the state the next cycle will be in.
  always_comb begin
    w_led_nxt = 1'b0;
    unique case (w_state_nxt)
      START:   w_led_nxt = 1'b1;
      DATA:    w_led_nxt = w_shreg_nxt[NBITS-1] ^ w_phase_nxt;
      default: w_led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
      r_phase <= 1'b0;
      r_bcnt  <= '0;
      r_shreg <= '0;
      r_led   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_phase <= w_phase_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_led   <= w_led_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.led  = r_led;
  assign bus.done = r_done;

endmodule

// File: tb/tb_led_encoder.sv
// Directed bench for led_encoder: default instance (HALF_CYCLES=1) and a HALF_CYCLES=3 instance.
`timescale 1ns/1ps

module tb_led_encoder;

`ifdef ENCODER_PARITY_EN
  localparam int FL  = 23;
  localparam int FL3 = 67;
  localparam logic [0:FL-1] EXP_B6 = 23'b01110011010011010011000;
  localparam logic [0:FL-1] EXP_00 = 23'b01101010101010101010100;
`else
  localparam int FL  = 21;
  localparam int FL3 = 61;
  localparam logic [0:FL-1] EXP_B6 = 21'b011100110100110100100;
  localparam logic [0:FL-1] EXP_00 = 21'b011010101010101010100;
`endif

  logic clock = 1'b0;
  logic clk_en = 1'b0;
  logic reset = 1'b0;
  logic rst3 = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  led_encoder_if #(.W(8)) bus ();
  led_encoder_if #(.W(8)) bus3 ();

  led_encoder #(.PACKET_SIZE(8), .HALF_CYCLES(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  led_encoder #(.PACKET_SIZE(8), .HALF_CYCLES(3)) dut3 (
    .clock (clock),
    .reset (rst3),
    .bus   (bus3.slave)
  );

  always #5 if (clk_en) clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Checks one frame from its IDLE cycle; leaves time at the next frame's cycle 0.
  task automatic frame(input string nm, input logic [0:FL-1] exp, input logic done0, input int chg_k);
    for (int k = 0; k < FL; k++) begin
      if (k == chg_k) bus.data = 8'h00;
      chk($sformatf("%s_led[%0d]", nm, k), 32'(bus.led), 32'(exp[k]));
      chk($sformatf("%s_done[%0d]", nm, k), 32'(bus.done), (k == 0) ? 32'(done0) : 32'd0);
      tick();
    end
  endtask

  initial begin
    bus.data  = 8'hB6;
    bus3.data = 8'h80;
    #1;
    reset = 1'b1;
    rst3  = 1'b1;
    #1;
    chk("rst_noclk_led", 32'(bus.led), 32'd0);
    chk("rst_noclk_done", 32'(bus.done), 32'd0);

    clk_en = 1'b1;
    repeat (3) tick();
    chk("rst_clk_led", 32'(bus.led), 32'd0);
    chk("rst_clk_done", 32'(bus.done), 32'd0);

    @(negedge clock);
    reset = 1'b0;
    #1;
    // Frame 0 carries 0xB6 even though data drops to 0x00 at cycle 5.
    frame("b6", EXP_B6, 1'b0, 5);
    frame("z1", EXP_00, 1'b1, -1);
    frame("z2", EXP_00, 1'b1, -1);
    chk("done_f3", 32'(bus.done), 32'd1);

    repeat (12) tick();
    chk("pre_rst_led", 32'(bus.led), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_led", 32'(bus.led), 32'd0);
    chk("rst_async_done", 32'(bus.done), 32'd0);
    bus.data = 8'hB6;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    frame("rb6", EXP_B6, 1'b0, -1);
    chk("done_after_rst", 32'(bus.done), 32'd1);
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);

    // HALF_CYCLES=3 with 0x80: 6-cycle START, bit 7 as 3 high + 3 low.
    @(negedge clock);
    rst3 = 1'b0;
    #1;
    for (int c = 0; c <= FL3; c++) begin
      logic exp_led;
      exp_led = ((c >= 1 && c <= 9) || (c >= 16 && c <= 18)) ? 1'b1 : 1'b0;
      if (c <= 18)
        chk($sformatf("h3_led[%0d]", c), 32'(bus3.led), 32'(exp_led));
      if (c >= FL3 - 6 && c < FL3)
        chk($sformatf("h3_stop[%0d]", c), 32'(bus3.led), 32'd0);
      chk($sformatf("h3_done[%0d]", c), 32'(bus3.done), (c == FL3) ? 32'd1 : 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
